vreg_wb_sequencer: RTL and testbench

//  Sequences vector-register writeback for LMUL register groups. Accepts one writeback request
//  (base register + vlmul) and emits per-beat register load masks to the vector register file,
//  WB_PORTS registers per beat, with valid/ready flow control on both sides.

---
 rtl/vreg_wb_pkg.sv | 23 ++
 rtl/vreg_group_decode.sv | 28 ++
 rtl/vreg_wb_sequencer.sv | 96 +++++++++
 tb/tb_vreg_wb_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vreg_wb_pkg.sv
// vreg_wb_pkg: shared types and group-geometry helpers for the vector-register writeback sequencer.
package vreg_wb_pkg;
    typedef enum logic [2:0] {LMUL1 = 3'd0, LMUL2 = 3'd1, LMUL4 = 3'd2, LMUL8 = 3'd3} vlmul_e;
    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;
    function automatic int idx_w(input int num_vregs);
        return $clog2(num_vregs);
    endfunction
    function automatic int beat_w(input int max_lmul_log2, input int ports);
        return (max_lmul_log2 - $clog2(ports)) > 1 ? max_lmul_log2 - $clog2(ports) : 1;
    endfunction
    function automatic int group_size(input logic [2:0] vlmul);
        return 1 << vlmul;
    endfunction
    function automatic int beat_count(input logic [2:0] vlmul, input int ports);
        return group_size(vlmul) > ports ? group_size(vlmul) / ports : 1;
    endfunction
    // A register belongs to the group when it shares the aligned high bits of sel.
    function automatic logic [63:0] group_mask(input int sel, input logic [2:0] vlmul);
        logic [63:0] m;
        for (int i = 0; i < 64; i++) m[i] = (i >> vlmul) == (sel >> vlmul);
        return m;
    endfunction
endpackage

// File: rtl/vreg_group_decode.sv
// vreg_group_decode: combinational (sel, vlmul, beat) -> register load mask, last-beat flag and legality.
module vreg_group_decode
    import vreg_wb_pkg::*;
#(
    parameter int NUM_VREGS     = 32,
    parameter int WB_PORTS      = 1,
    parameter int MAX_LMUL_LOG2 = 3,
    parameter int IDX_W         = idx_w(NUM_VREGS),
    parameter int BEAT_W        = beat_w(MAX_LMUL_LOG2, WB_PORTS)
) (
    input  logic [IDX_W:0]       sel,
    input  logic [2:0]           vlmul,
    input  logic [BEAT_W-1:0]    beat,
    output logic [NUM_VREGS-1:0] mask,
    output logic                 last,
    output logic                 illegal
);
    int g, r, lo;
    always_comb begin
        illegal = sel[IDX_W] | (int'(vlmul) > MAX_LMUL_LOG2);
        g = illegal ? 1 : group_size(vlmul);
        r = g < WB_PORTS ? g : WB_PORTS;
        lo = (int'(sel[IDX_W-1:0]) & ~(g - 1)) + int'(beat) * r;
        last = int'(beat) == beat_count(vlmul, WB_PORTS) - 1;
        mask = '0;
        for (int i = 0; i < NUM_VREGS; i++) mask[i] = i >= lo && i < lo + r;
    end
endmodule

// File: rtl/vreg_wb_sequencer.sv
// vreg_wb_sequencer: turns one LMUL writeback request into per-beat VRF load masks, valid/ready on both sides.
// Defining VREG_WB_PENDING_EN adds pending_mask: registers of the group in flight not yet written.
module vreg_wb_sequencer
    import vreg_wb_pkg::*;
#(
    parameter int NUM_VREGS     = 32,
    parameter int WB_PORTS      = 1,
    parameter int MAX_LMUL_LOG2 = 3,
    localparam int IDX_W        = idx_w(NUM_VREGS),
    localparam int BEAT_W       = beat_w(MAX_LMUL_LOG2, WB_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [IDX_W:0]       wb_sel,
    input  logic [2:0]           wb_vlmul,
    output logic [NUM_VREGS-1:0] rf_load,
    output logic                 rf_valid,
    input  logic                 rf_ready,
    output logic [BEAT_W-1:0]    rf_beat,
    output logic                 rf_last,
    output logic                 wb_err,
`ifdef VREG_WB_PENDING_EN
    output logic [NUM_VREGS-1:0] pending_mask,
`endif
    output logic                 busy
);
    state_e state, state_nx;
    logic [IDX_W:0] sel_q, d_sel;
    logic [2:0] vlmul_q, d_vlmul;
    logic [BEAT_W-1:0] d_beat;
    logic [NUM_VREGS-1:0] d_mask;
    logic d_last, d_illegal, acc, start, adv, done;

    assign rf_valid = state == ISSUE;
    assign busy     = state == ISSUE;
    assign done     = rf_valid & rf_ready & rf_last;
    assign adv      = rf_valid & rf_ready & ~rf_last;
    assign wb_ready = (state == IDLE) | done;
    assign acc      = wb_valid & wb_ready;
    assign start    = acc & ~d_illegal;
    // One decoder serves both a fresh accept (beat 0) and advancing the stored group.
    assign d_sel    = acc ? wb_sel : sel_q;
    assign d_vlmul  = acc ? wb_vlmul : vlmul_q;
    assign d_beat   = acc ? '0 : rf_beat + BEAT_W'(1);

    vreg_group_decode #(
        .NUM_VREGS(NUM_VREGS), .WB_PORTS(WB_PORTS), .MAX_LMUL_LOG2(MAX_LMUL_LOG2),
        .IDX_W(IDX_W), .BEAT_W(BEAT_W)
    ) u_dec (
        .sel(d_sel), .vlmul(d_vlmul), .beat(d_beat),
        .mask(d_mask), .last(d_last), .illegal(d_illegal)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = start ? ISSUE : done ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sel_q   <= '0;
            vlmul_q <= '0;
            rf_load <= '0;
            rf_beat <= '0;
            rf_last <= 1'b0;
            wb_err  <= 1'b0;
        end else begin
            wb_err <= acc & d_illegal;
            if (start) begin
                sel_q   <= wb_sel;
                vlmul_q <= wb_vlmul;
            end
            if (start | adv) begin
                rf_load <= d_mask;
                rf_beat <= d_beat;
                rf_last <= d_last;
            end else if (done) begin
                rf_load <= '0;
                rf_beat <= '0;
                rf_last <= 1'b0;
            end
        end

`ifdef VREG_WB_PENDING_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pending_mask <= '0;
        else if (start) pending_mask <= NUM_VREGS'(group_mask(int'(wb_sel[IDX_W-1:0]), wb_vlmul));
        else if (rf_valid & rf_ready) pending_mask <= pending_mask & ~rf_load;
`endif
endmodule

// File: tb/tb_vreg_wb_sequencer.sv
// tb_vreg_wb_sequencer: scoreboard bench driving a 1-port and a 2-port sequencer.
module tb_vreg_wb_sequencer;
    typedef struct packed {
        logic [31:0] load;
        logic [2:0]  beat;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] wb_valid = '0;
    logic [1:0] rf_ready = '1;
    logic [1:0][5:0] wb_sel = '0;
    logic [1:0][2:0] wb_vlmul = '0;
    logic [1:0] wb_ready, rf_valid, rf_last, wb_err, busy;
    logic [1:0][31:0] rf_load;
    logic [2:0] beat_u1;
    logic [1:0] beat_u2;
`ifdef VREG_WB_PENDING_EN
    logic [31:0] pend0, pend1;
`endif
    exp_t q0[$], q1[$];
    exp_t me;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    vreg_wb_sequencer #(.NUM_VREGS(32), .WB_PORTS(1), .MAX_LMUL_LOG2(3)) u1 (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid[0]), .wb_ready(wb_ready[0]),
        .wb_sel(wb_sel[0]), .wb_vlmul(wb_vlmul[0]), .rf_load(rf_load[0]), .rf_valid(rf_valid[0]),
        .rf_ready(rf_ready[0]), .rf_beat(beat_u1), .rf_last(rf_last[0]), .wb_err(wb_err[0]),
`ifdef VREG_WB_PENDING_EN
        .pending_mask(pend0),
`endif
        .busy(busy[0])
    );

    vreg_wb_sequencer #(.NUM_VREGS(32), .WB_PORTS(2), .MAX_LMUL_LOG2(3)) u2 (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid[1]), .wb_ready(wb_ready[1]),
        .wb_sel(wb_sel[1]), .wb_vlmul(wb_vlmul[1]), .rf_load(rf_load[1]), .rf_valid(rf_valid[1]),
        .rf_ready(rf_ready[1]), .rf_beat(beat_u2), .rf_last(rf_last[1]), .wb_err(wb_err[1]),
`ifdef VREG_WB_PENDING_EN
        .pending_mask(pend1),
`endif
        .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] beat_of(input int k);
        return k == 0 ? beat_u1 : {1'b0, beat_u2};
    endfunction

    // Expected beats straight from the group geometry: G regs from the aligned base, R per beat.
    task automatic push_group(input int k, input logic [5:0] sel, input logic [2:0] vl);
        int g = 1 << vl;
        int p = k == 0 ? 1 : 2;
        int r = g < p ? g : p;
        int n = g > p ? g / p : 1;
        int base = int'(sel) & ~(g - 1);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            e.load = ((32'd1 << r) - 32'd1) << (base + b * r);
            e.beat = 3'(b);
            e.last = b == n - 1;
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic check_reset(input int k);
        check("rst_load", rf_load[k], 32'h0);
        check("rst_valid", 32'(rf_valid[k]), 0);
        check("rst_beat", 32'(beat_of(k)), 0);
        check("rst_last", 32'(rf_last[k]), 0);
        check("rst_err", 32'(wb_err[k]), 0);
        check("rst_busy", 32'(busy[k]), 0);
    endtask

    // Called and returns at posedge+1; holds the request until accepted, then checks latency or error pulse.
    task automatic send(input int k, input logic [5:0] sel, input logic [2:0] vl);
        int n = 0;
        bit legal = vl <= 3'd3 && !sel[5];
        wb_valid[k] = 1'b1;
        wb_sel[k] = sel;
        wb_vlmul[k] = vl;
        @(negedge clk);
        while (!wb_ready[k] && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(wb_ready[k]), 1);
        if (legal) push_group(k, sel, vl);
        @(posedge clk);
        #1 wb_valid[k] = 1'b0;
        @(negedge clk);
        check("err_pulse", 32'(wb_err[k]), 32'(!legal));
        if (legal) begin
            check("lat_valid", 32'(rf_valid[k]), 1);
            check("lat_beat0", 32'(beat_of(k)), 0);
        end else begin
            check("err_no_beat", 32'(rf_valid[k]), 0);
            @(negedge clk);
            check("err_one_cycle", 32'(wb_err[k]), 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy[k]), 0);
        @(posedge clk);
        #1;
    endtask

    logic [1:0][31:0] pl;
    logic [1:0][2:0] pb;
    logic [1:0] plast;
    logic [1:0] stl = '0;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (stl[k]) begin
                check("hold_valid", 32'(rf_valid[k]), 1);
                check("hold_load", rf_load[k], pl[k]);
                check("hold_beat", 32'(beat_of(k)), 32'(pb[k]));
                check("hold_last", 32'(rf_last[k]), 32'(plast[k]));
            end
            if (rf_valid[k] && rf_ready[k]) begin
                if ((k == 0 ? q0.size() : q1.size()) == 0) check("unexpected_beat", rf_load[k], 32'h0);
                else begin
                    if (k == 0) me = q0.pop_front();
                    else me = q1.pop_front();
                    check("beat_load", rf_load[k], me.load);
                    check("beat_idx", 32'(beat_of(k)), 32'(me.beat));
                    check("beat_last", 32'(rf_last[k]), 32'(me.last));
                end
            end else if (!rf_valid[k]) check("idle_load_zero", rf_load[k], 32'h0);
            stl[k] = rf_valid[k] & ~rf_ready[k];
            pl[k] = rf_load[k];
            pb[k] = beat_of(k);
            plast[k] = rf_last[k];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(wb_ready[0]), 1);
        check("ready_after_reset2", 32'(wb_ready[1]), 1);
        @(posedge clk);
        #1;
        send(0, 6'd5, 3'd0);
        wait_idle(0);
        send(0, 6'd13, 3'd2);
        wait_idle(0);
        send(1, 6'd16, 3'd3);
        wait_idle(1);
        send(0, 6'd13, 3'd2);
        rf_ready[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rf_ready[0] = 1'b1;
        wait_idle(0);
        send(0, 6'd13, 3'd2);
        send(0, 6'd4, 3'd1);
        wait_idle(0);
        send(1, 6'd0, 3'd1);
        send(1, 6'd6, 3'd2);
        wait_idle(1);
        send(0, 6'd7, 3'd2);
        wait_idle(0);
        send(1, 6'd3, 3'd0);
        wait_idle(1);
        send(0, 6'd5, 3'd5);
        send(0, 6'h20, 3'd0);
        send(1, 6'h21, 3'd1);
        send(0, 6'd13, 3'd2);
        send(0, 6'h20, 3'd1);
        check("err_back_idle", 32'(busy[0]), 0);
        send(0, 6'd8, 3'd3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        q0.delete();
        #1 check_reset(0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_replay", 32'(rf_valid[0]), 0);
        end
        @(posedge clk);
        #1;
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
